// File: rtl/rs5_plic.sv
// rs5_plic: platform-level interrupt controller for the RS5 SoC.
// Per-source 3-bit priority, enable bitmap and global threshold select the
// highest-priority pending source; the core claims it with a bus read and
// completes it with a bus write. Read data and acknowledges are registered.
module rs5_plic #(
  parameter int i_cnt = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en_i,
  input  logic [3:0]     we_i,
  input  logic [23:0]    addr_i,
  input  logic [31:0]    data_i,
  output logic [31:0]    data_o,
  input  logic [i_cnt:1] irq_i,
  input  logic           iack_i,
  output logic [i_cnt:1] iack_o,
  output logic           irq_o
);

  // Word offsets (byte offset >> 2) of the non-priority registers.
  localparam logic [21:0] PEND_WORD   = 22'h000400;
  localparam logic [21:0] ENABLE_WORD = 22'h000800;
  localparam logic [21:0] THRESH_WORD = 22'h080000;
  localparam logic [21:0] CLAIM_WORD  = 22'h080001;

  logic [2:0]     prio_q [i_cnt:1];
  logic [2:0]     prio_d [i_cnt:1];
  logic [i_cnt:1] enable_q, enable_d;
  logic [i_cnt:1] pending_q, pending_d;
  logic [i_cnt:1] in_service_q, in_service_d;
  logic [i_cnt:1] iack_q, iack_d;
  logic [2:0]     threshold_q, threshold_d;
  logic [31:0]    data_q, data_d;

  logic           rd_s;
  logic           wr_s;
  logic [21:0]    word_s;
  logic [4:0]     prio_id_s;
  logic           sel_prio_s;
  logic           claim_s;
  logic           complete_s;
  logic [4:0]     max_id_s;
  logic [2:0]     best_prio_s;
  logic [31:0]    rdata_s;
  logic           unused_s;

  assign rd_s       = en_i & (we_i == 4'h0);
  assign wr_s       = en_i & (we_i != 4'h0);
  assign word_s     = addr_i[23:2];
  assign prio_id_s  = addr_i[6:2];
  // Priority registers live at 0x04..0x7C; offset 0 (ID 0) is not a register.
  assign sel_prio_s = (addr_i[23:7] == 17'h00000) & (prio_id_s != 5'd0) &
                      ({27'd0, prio_id_s} <= 32'(i_cnt));
  assign claim_s    = rd_s & (word_s == CLAIM_WORD) & (max_id_s != 5'd0);
  assign complete_s = wr_s & (word_s == CLAIM_WORD);

  // Only the low field bits of write data and the word part of the address matter.
  assign unused_s   = ^{data_i, addr_i[1:0]};

  assign data_o = data_q;
  assign iack_o = iack_q;
  assign irq_o  = (max_id_s != 5'd0);

  // Arbitration: strict greater-than keeps the lowest ID on priority ties,
  // and seeding with the threshold excludes priority 0 and sub-threshold sources.
  always_comb begin
    max_id_s    = 5'd0;
    best_prio_s = threshold_q;
    for (int id = 1; id <= i_cnt; id++) begin
      if (pending_q[id] && enable_q[id] && (prio_q[id] > best_prio_s)) begin
        max_id_s    = 5'(id);
        best_prio_s = prio_q[id];
      end else begin
        max_id_s    = max_id_s;
        best_prio_s = best_prio_s;
      end
    end
  end

  // Read multiplexer for the register map; unmapped offsets return zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (sel_prio_s) begin
      for (int id = 1; id <= i_cnt; id++) begin
        if (prio_id_s == 5'(id)) begin
          rdata_s = {29'd0, prio_q[id]};
        end else begin
          rdata_s = rdata_s;
        end
      end
    end else if (word_s == PEND_WORD) begin
      for (int id = 1; id <= i_cnt; id++) begin
        rdata_s[id] = pending_q[id];
      end
    end else if (word_s == ENABLE_WORD) begin
      for (int id = 1; id <= i_cnt; id++) begin
        rdata_s[id] = enable_q[id];
      end
    end else if (word_s == THRESH_WORD) begin
      rdata_s = {29'd0, threshold_q};
    end else if (word_s == CLAIM_WORD) begin
      rdata_s = {27'd0, max_id_s};
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Next-state: register writes, gateways, claim/complete and acknowledge.
  always_comb begin
    prio_d       = prio_q;
    enable_d     = enable_q;
    threshold_d  = threshold_q;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    iack_d       = '0;
    data_d       = data_q;

    if (rd_s) begin
      data_d = rdata_s;
    end else begin
      data_d = data_q;
    end

    if (wr_s && (word_s == ENABLE_WORD)) begin
      enable_d = data_i[i_cnt:1];
    end else begin
      enable_d = enable_q;
    end

    if (wr_s && (word_s == THRESH_WORD)) begin
      threshold_d = data_i[2:0];
    end else begin
      threshold_d = threshold_q;
    end

    for (int id = 1; id <= i_cnt; id++) begin
      if (wr_s && sel_prio_s && (prio_id_s == 5'(id))) begin
        prio_d[id] = data_i[2:0];
      end else begin
        prio_d[id] = prio_q[id];
      end

      // A claim needs pending=1 while the gateway needs pending=0, so the
      // two never compete for the same source on one edge.
      if (claim_s && (max_id_s == 5'(id))) begin
        pending_d[id]    = 1'b0;
        in_service_d[id] = 1'b1;
      end else if (complete_s && (data_i[4:0] == 5'(id))) begin
        in_service_d[id] = 1'b0;
        pending_d[id]    = pending_q[id];
      end else begin
        in_service_d[id] = in_service_q[id];
        pending_d[id]    = pending_q[id];
      end

      // Gateway looks at the registered in_service, so a same-edge complete
      // lets the source become pending only on the following edge.
      if (irq_i[id] && !pending_q[id] && !in_service_q[id]) begin
        pending_d[id] = 1'b1;
      end else begin
        pending_d[id] = pending_d[id];
      end

      iack_d[id] = iack_i & (max_id_s == 5'(id));
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int id = 1; id <= i_cnt; id++) begin
        prio_q[id] <= 3'd0;
      end
      enable_q     <= '0;
      threshold_q  <= 3'd0;
      pending_q    <= '0;
      in_service_q <= '0;
      iack_q       <= '0;
      data_q       <= 32'h0000_0000;
    end else begin
      prio_q       <= prio_d;
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      iack_q       <= iack_d;
      data_q       <= data_d;
    end
  end

endmodule

// File: tb/tb_rs5_plic.sv
// tb_rs5_plic: directed and randomized checks of rs5_plic (three sources)
// against a behavioural model of the interrupt controller.
module tb_rs5_plic;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en_i;
  logic [3:0]    we_i;
  logic [23:0]   addr_i;
  logic [31:0]   data_i;
  logic [31:0]   data_o;
  logic [N:1]    irq_i;
  logic          iack_i;
  logic [N:1]    iack_o;
  logic          irq_o;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  int          m_prio [N+1];
  logic [N:1]  m_en, m_pend, m_insvc, m_iack;
  int          m_thr;
  logic [31:0] m_data;

  rs5_plic #(.i_cnt(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (en_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .data_o  (data_o),
    .irq_i   (irq_i),
    .iack_i  (iack_i),
    .iack_o  (iack_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  // Winner = candidate maximising (priority, then smallest ID) as one score.
  function automatic int m_max_id();
    int best;
    int best_score;
    int score;
    best = 0;
    best_score = -1;
    for (int id = 1; id <= N; id++) begin
      if (m_pend[id] && m_en[id] && (m_prio[id] > m_thr)) begin
        score = m_prio[id] * 64 + (63 - id);
        if (score > best_score) begin
          best_score = score;
          best = id;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] m_read(int a);
    logic [31:0] v;
    v = 32'h0;
    if (a >= 4 && a <= 4 * N) v = 32'(m_prio[a / 4]);
    else if (a == 32'h1000) begin
      for (int id = 1; id <= N; id++) v[id] = m_pend[id];
    end
    else if (a == 32'h2000) begin
      for (int id = 1; id <= N; id++) v[id] = m_en[id];
    end
    else if (a == 32'h200000) v = 32'(m_thr);
    else if (a == 32'h200004) v = 32'(m_max_id());
    return v;
  endfunction

  task automatic m_reset();
    for (int id = 0; id <= N; id++) m_prio[id] = 0;
    m_en = '0; m_pend = '0; m_insvc = '0; m_iack = '0;
    m_thr = 0; m_data = 32'h0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model over one edge using the inputs now applied, clock the
  // DUT, then compare every output just after the edge.
  task automatic tick();
    int         mid;
    int         a;
    int         cid;
    logic [N:1] np, ni;
    mid = m_max_id();
    np  = m_pend;
    ni  = m_insvc;
    a   = int'({addr_i[23:2], 2'b00});
    cid = int'(data_i[4:0]);
    if (en_i && we_i == 4'h0) begin
      m_data = m_read(a);
      if (a == 32'h200004 && mid != 0) begin
        np[mid] = 1'b0;
        ni[mid] = 1'b1;
      end
    end
    if (en_i && we_i != 4'h0) begin
      if (a >= 4 && a <= 4 * N) m_prio[a / 4] = int'(data_i[2:0]);
      else if (a == 32'h2000) m_en = data_i[N:1];
      else if (a == 32'h200000) m_thr = int'(data_i[2:0]);
      else if (a == 32'h200004 && cid >= 1 && cid <= N) ni[cid] = 1'b0;
    end
    for (int id = 1; id <= N; id++)
      if (irq_i[id] && !m_pend[id] && !m_insvc[id]) np[id] = 1'b1;
    m_iack = '0;
    if (iack_i && mid != 0) m_iack[mid] = 1'b1;
    m_pend  = np;
    m_insvc = ni;
    @(posedge clk);
    #1;
    check("irq_o", 32'(irq_o), 32'(m_max_id() != 0));
    check("data_o", data_o, m_data);
    check("iack_o", 32'(iack_o), 32'(m_iack));
  endtask

  task automatic wr(logic [23:0] a, logic [31:0] d);
    en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
    tick();
    en_i = 1'b0; we_i = 4'h0;
  endtask

  task automatic rd(logic [23:0] a);
    en_i = 1'b1; we_i = 4'h0; addr_i = a;
    tick();
    en_i = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          op;
    reset_n = 1'b0; en_i = 1'b0; we_i = 4'h0; addr_i = 24'h0;
    data_i = 32'h0; irq_i = '0; iack_i = 1'b0;
    m_reset();
    #12;
    check("rst_data_o", data_o, 32'h0);
    check("rst_irq_o", 32'(irq_o), 32'h0);
    check("rst_iack_o", 32'(iack_o), 32'h0);
    reset_n = 1'b1;

    // Basic flow on source 1
    wr(24'h000004, 32'd3); wr(24'h002000, 32'h2); wr(24'h200000, 32'd0);
    irq_i = 3'b001; tick(); irq_i = '0;
    check("basic_irq", 32'(irq_o), 32'h1);
    rd(24'h001000); check("basic_pend", data_o, 32'h2);
    rd(24'h200004); check("basic_claim", data_o, 32'h1);
    check("basic_irq_fall", 32'(irq_o), 32'h0);
    irq_i = 3'b001; tick(); irq_i = '0;
    rd(24'h001000); check("insvc_ignores_irq", data_o, 32'h0);
    irq_i = 3'b001; wr(24'h200004, 32'd1);
    check("cpl_same_edge", 32'(irq_o), 32'h0);
    tick(); irq_i = '0;
    check("cpl_next_edge", 32'(irq_o), 32'h1);
    rd(24'h001000); check("repend", data_o, 32'h2);
    rd(24'h200004); check("claim_again", data_o, 32'h1);
    wr(24'h200004, 32'd1);

    // Threshold
    wr(24'h000004, 32'd2); wr(24'h200000, 32'd2);
    irq_i = 3'b001; tick(); irq_i = '0; tick();
    check("thr_block", 32'(irq_o), 32'h0);
    wr(24'h200000, 32'd1);
    check("thr_pass", 32'(irq_o), 32'h1);
    rd(24'h200004); check("thr_claim", data_o, 32'h1);
    wr(24'h200004, 32'd1);
    wr(24'h000004, 32'hFF); rd(24'h000004); check("prio_trunc", data_o, 32'h7);

    // Arbitration
    wr(24'h000004, 32'd1); wr(24'h000008, 32'd5); wr(24'h00000C, 32'd5);
    wr(24'h002000, 32'hE); wr(24'h200000, 32'd0);
    irq_i = 3'b111; tick(); irq_i = '0;
    rd(24'h200004); check("arb_1st", data_o, 32'd2);
    rd(24'h200004); check("arb_2nd", data_o, 32'd3);
    rd(24'h200004); check("arb_3rd", data_o, 32'd1);
    rd(24'h200004); check("arb_none", data_o, 32'd0);
    wr(24'h200004, 32'd1); wr(24'h200004, 32'd2); wr(24'h200004, 32'd3);

    // Acknowledge
    irq_i = 3'b001; tick(); irq_i = '0;
    iack_i = 1'b1; tick(); iack_i = 1'b0;
    check("iack_pulse", 32'(iack_o), 32'h1);
    tick(); check("iack_one_cycle", 32'(iack_o), 32'h0);
    rd(24'h200004); check("ack_claim", data_o, 32'd1);
    iack_i = 1'b1; tick(); iack_i = 1'b0;
    check("iack_no_cand", 32'(iack_o), 32'h0);

    // Completion of out-of-range IDs, empty claim, unmapped offsets
    wr(24'h200004, 32'd0); wr(24'h200004, 32'd5);
    irq_i = 3'b001; tick(); irq_i = '0;
    rd(24'h001000); check("bad_cpl_noop", data_o, 32'h0);
    wr(24'h200004, 32'd1);
    rd(24'h200004); check("empty_claim", data_o, 32'd0);
    wr(24'h100000, 32'hFFFF_FFFF);
    rd(24'h100000); check("unmapped", data_o, 32'h0);
    rd(24'h000000); check("prio0_reads0", data_o, 32'h0);

    // Reset in the middle of activity
    rd(24'h002000);
    irq_i = 3'b111; tick(); irq_i = '0;
    iack_i = 1'b1; tick(); iack_i = 1'b0;
    #3; reset_n = 1'b0; #1;
    check("mid_rst_data_o", data_o, 32'h0);
    check("mid_rst_irq_o", 32'(irq_o), 32'h0);
    check("mid_rst_iack_o", 32'(iack_o), 32'h0);
    m_reset();
    #2; reset_n = 1'b1;
    tick();
    rd(24'h000004); check("rst_prio1", data_o, 32'h0);
    rd(24'h000008); check("rst_prio2", data_o, 32'h0);
    rd(24'h001000); check("rst_pend", data_o, 32'h0);
    rd(24'h002000); check("rst_en", data_o, 32'h0);
    rd(24'h200000); check("rst_thr", data_o, 32'h0);
    rd(24'h200004); check("rst_claim", data_o, 32'h0);

    // Randomized traffic checked against the model
    for (int i = 0; i < 1500; i++) begin
      irq_i  = N'($urandom);
      iack_i = ($urandom_range(0, 3) == 0);
      op     = int'($urandom_range(0, 9));
      d      = $urandom;
      en_i   = 1'b0; we_i = 4'h0;
      addr_i = 24'($urandom_range(0, 3));
      data_i = d;
      case (op)
        3, 4: begin en_i = 1'b1; addr_i = addr_i | 24'h200004; end
        5: begin
          en_i = 1'b1; we_i = 4'($urandom_range(1, 15));
          addr_i = addr_i | 24'h200004;
          d[4:0] = 5'($urandom_range(0, 7)); data_i = d;
        end
        6: begin
          en_i = 1'b1; we_i = 4'($urandom_range(1, 15));
          addr_i = addr_i | 24'(4 * $urandom_range(0, N + 1));
        end
        7: begin en_i = 1'b1; we_i = 4'($urandom_range(1, 15)); addr_i = addr_i | 24'h002000; end
        8: begin
          en_i = 1'b1; we_i = 4'($urandom_range(1, 15)); addr_i = addr_i | 24'h200000;
          d[2:0] = 3'($urandom_range(0, 3)); data_i = d;
        end
        9: begin
          en_i = 1'b1;
          case ($urandom_range(0, 4))
            0: addr_i = addr_i | 24'h001000;
            1: addr_i = addr_i | 24'h002000;
            2: addr_i = addr_i | 24'h100000;
            3: addr_i = addr_i | 24'(4 * $urandom_range(0, N + 2));
            default: addr_i = addr_i | 24'h200000;
          endcase
        end
        default: en_i = 1'b0;
      endcase
      tick();
    end
    en_i = 1'b0; we_i = 4'h0; irq_i = '0; iack_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
